io_responder: RTL and testbench



---
 rtl/chimpo_io_pkg.sv | 14 +
 rtl/io_responder_if.sv | 33 +++
 rtl/io_fifo.sv | 50 +++++
 rtl/io_responder.sv | 76 +++++++
 tb/tb_io_responder.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/chimpo_io_pkg.sv
// Chimpo I/O shared definitions.
// Port addresses, word width and output FSM states.
package chimpo_io_pkg;

  localparam int IO_IN_ADDR  = 1024;
  localparam int IO_OUT_ADDR = 1026;
  localparam int IO_WIDTH    = 16;

  typedef enum logic {
    OUT_IDLE,
    OUT_HOLD
  } out_state_t;

endpackage

// File: rtl/io_responder_if.sv
// Processor-side and board-side signals of the I/O responder.
// slave is the responder view, master the processor/board view.
interface io_responder_if #(
  parameter int WIDTH = chimpo_io_pkg::IO_WIDTH
);

  logic             in_sel;
  logic             out_sel;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd_data;
  logic             stall;
  logic [WIDTH-1:0] ext_in_data;
  logic             ext_in_valid;
  logic             ext_in_ready;
  logic [WIDTH-1:0] ext_out_data;
  logic             ext_out_valid;
  logic             ext_out_ack;

  modport slave (
    input  in_sel, out_sel, wr_data,
    input  ext_in_data, ext_in_valid, ext_out_ack,
    output rd_data, stall, ext_in_ready,
    output ext_out_data, ext_out_valid
  );

  modport master (
    output in_sel, out_sel, wr_data,
    output ext_in_data, ext_in_valid, ext_out_ack,
    input  rd_data, stall, ext_in_ready,
    input  ext_out_data, ext_out_valid
  );

endinterface

// File: rtl/io_fifo.sv
// Small synchronous FIFO for board input words.
// Head is combinational and reads zero when empty.
module io_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // storage write, no reset needed since head is masked when empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/io_responder.sv
// Chimpo memory-mapped I/O responder.
// Input FIFO, held output word with valid/ack, stall generation.
module io_responder
  import chimpo_io_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         reset,
  io_responder_if.slave bus
);

  out_state_t       state_q;
  out_state_t       state_d;
  logic [WIDTH-1:0] data_q;
  logic             load;
  logic             fifo_full;
  logic             fifo_empty;
  logic             out_stall;

  io_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.ext_in_valid && !fifo_full),
    .pop   (bus.in_sel),
    .din   (bus.ext_in_data),
    .dout  (bus.rd_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.ext_in_ready  = !fifo_full;
  assign bus.ext_out_valid = (state_q == OUT_HOLD);
  assign bus.ext_out_data  = data_q;
  assign bus.stall = (bus.in_sel && fifo_empty) || out_stall;

  // output FSM next state, load and write stall
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    out_stall = 1'b0;
    unique case (state_q)
      OUT_IDLE: begin
        if (bus.out_sel) begin
          load    = 1'b1;
          state_d = OUT_HOLD;
        end
      end
      OUT_HOLD: begin
        if (bus.ext_out_ack) begin
          if (bus.out_sel) load = 1'b1;
          else state_d = OUT_IDLE;
        end else if (bus.out_sel) begin
          out_stall = 1'b1;
        end
      end
      default: state_d = OUT_IDLE;
    endcase
  end

  // output state and held word
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OUT_IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) data_q <= bus.wr_data;
    end
  end

endmodule

// File: tb/tb_io_responder.sv
// Testbench for io_responder.
// Directed vector table plus reset sequences.
module tb_io_responder;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  io_responder_if #(.WIDTH(16)) bus ();

  io_responder #(.WIDTH(16), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        isel;
    logic        osel;
    logic [15:0] wd;
    logic [15:0] id;
    logic        iv;
    logic        ack;
    logic [15:0] rd;
    logic        st;
    logic        rdy;
    logic        ov;
    logic [15:0] od;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic isel, input logic osel,
                     input logic [15:0] wd, input logic [15:0] id,
                     input logic iv, input logic ack,
                     input logic [15:0] rd, input logic st,
                     input logic rdy, input logic ov,
                     input logic [15:0] od);
    vec_t v;
    v.isel = isel; v.osel = osel; v.wd = wd; v.id = id;
    v.iv = iv; v.ack = ack; v.rd = rd; v.st = st;
    v.rdy = rdy; v.ov = ov; v.od = od;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h",
               name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic isel, input logic osel,
                       input logic [15:0] wd, input logic [15:0] id,
                       input logic iv, input logic ack);
    bus.in_sel       = isel;
    bus.out_sel      = osel;
    bus.wr_data      = wd;
    bus.ext_in_data  = id;
    bus.ext_in_valid = iv;
    bus.ext_out_ack  = ack;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    idle_inputs();

    // reset held two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ov",  -1, 32'(bus.ext_out_valid), 32'd0);
    check("rst_rdy", -1, 32'(bus.ext_in_ready), 32'd1);
    check("rst_rd",  -1, 32'(bus.rd_data), 32'd0);
    check("rst_st",  -1, 32'(bus.stall), 32'd0);
    check("rst_od",  -1, 32'(bus.ext_out_data), 32'd0);
    reset = 1'b0;

    //  isel osel wd     id     iv ack | rd     st rdy ov od
    // basic read
    add(0, 0, 16'h0, 16'h1234, 1, 0,  16'h0000, 0, 1, 0, 16'h0);
    add(0, 0, 16'h0, 16'hBEEF, 1, 0,  16'h1234, 0, 1, 0, 16'h0);
    add(1, 0, 16'h0, 16'h0,    0, 0,  16'h1234, 0, 1, 0, 16'h0);
    add(1, 0, 16'h0, 16'h0,    0, 0,  16'hBEEF, 0, 1, 0, 16'h0);
    add(1, 0, 16'h0, 16'h0,    0, 0,  16'h0000, 1, 1, 0, 16'h0);
    add(1, 0, 16'h0, 16'h0111, 1, 0,  16'h0000, 1, 1, 0, 16'h0);
    add(1, 0, 16'h0, 16'h0,    0, 0,  16'h0111, 0, 1, 0, 16'h0);
    // fill to full, pointers start at 3 so they wrap
    add(0, 0, 16'h0, 16'h00A1, 1, 0,  16'h0000, 0, 1, 0, 16'h0);
    add(0, 0, 16'h0, 16'h00A2, 1, 0,  16'h00A1, 0, 1, 0, 16'h0);
    add(0, 0, 16'h0, 16'h00A3, 1, 0,  16'h00A1, 0, 1, 0, 16'h0);
    add(0, 0, 16'h0, 16'h00A4, 1, 0,  16'h00A1, 0, 1, 0, 16'h0);
    add(0, 0, 16'h0, 16'h00A5, 1, 0,  16'h00A1, 0, 0, 0, 16'h0);
    add(1, 0, 16'h0, 16'h00A5, 1, 0,  16'h00A1, 0, 0, 0, 16'h0);
    add(0, 0, 16'h0, 16'h00A5, 1, 0,  16'h00A2, 0, 1, 0, 16'h0);
    add(1, 0, 16'h0, 16'h0,    0, 0,  16'h00A2, 0, 0, 0, 16'h0);
    add(1, 0, 16'h0, 16'h0,    0, 0,  16'h00A3, 0, 1, 0, 16'h0);
    add(1, 0, 16'h0, 16'h0,    0, 0,  16'h00A4, 0, 1, 0, 16'h0);
    add(1, 0, 16'h0, 16'h0,    0, 0,  16'h00A5, 0, 1, 0, 16'h0);
    add(1, 0, 16'h0, 16'h0,    0, 0,  16'h0000, 1, 1, 0, 16'h0);
    // write while busy, back-to-back on ack
    add(0, 1, 16'h00A5, 16'h0, 0, 0,  16'h0000, 0, 1, 0, 16'h0);
    add(0, 1, 16'h005A, 16'h0, 0, 0,  16'h0000, 1, 1, 1, 16'h00A5);
    add(0, 1, 16'h005A, 16'h0, 0, 1,  16'h0000, 0, 1, 1, 16'h00A5);
    add(0, 0, 16'h0,    16'h0, 0, 0,  16'h0000, 0, 1, 1, 16'h005A);
    add(0, 0, 16'h0,    16'h0, 0, 1,  16'h0000, 0, 1, 1, 16'h005A);
    add(0, 0, 16'h0,    16'h0, 0, 0,  16'h0000, 0, 1, 0, 16'h0);
    // ack while idle is ignored
    add(0, 0, 16'h0,    16'h0, 0, 1,  16'h0000, 0, 1, 0, 16'h0);
    add(0, 0, 16'h0,    16'h0, 0, 0,  16'h0000, 0, 1, 0, 16'h0);
    // in_sel and out_sel together, serviced independently
    add(1, 1, 16'h0C3C, 16'h0, 0, 0,  16'h0000, 1, 1, 0, 16'h0);
    add(0, 0, 16'h0,    16'h0, 0, 0,  16'h0000, 0, 1, 1, 16'h0C3C);
    add(0, 0, 16'h0,    16'h0, 0, 1,  16'h0000, 0, 1, 1, 16'h0C3C);
    add(0, 0, 16'h0,    16'h0, 0, 0,  16'h0000, 0, 1, 0, 16'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].isel, vecs[i].osel, vecs[i].wd,
            vecs[i].id, vecs[i].iv, vecs[i].ack);
      #1;
      check("rd_data", i, 32'(bus.rd_data), 32'(vecs[i].rd));
      check("stall", i, 32'(bus.stall), 32'(vecs[i].st));
      check("in_ready", i, 32'(bus.ext_in_ready), 32'(vecs[i].rdy));
      check("out_valid", i, 32'(bus.ext_out_valid), 32'(vecs[i].ov));
      if (vecs[i].ov)
        check("out_data", i, 32'(bus.ext_out_data), 32'(vecs[i].od));
    end

    // reset mid-operation: 3 words buffered, output pending
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 16'h1111, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 16'h2222, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h7777, 16'h3333, 1'b1, 1'b0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("mid_pre_rd", 100, 32'(bus.rd_data), 32'h1111);
    check("mid_pre_ov", 100, 32'(bus.ext_out_valid), 32'd1);
    check("mid_pre_od", 100, 32'(bus.ext_out_data), 32'h7777);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rd",  101, 32'(bus.rd_data), 32'd0);
    check("mid_ov",  101, 32'(bus.ext_out_valid), 32'd0);
    check("mid_od",  101, 32'(bus.ext_out_data), 32'd0);
    check("mid_rdy", 101, 32'(bus.ext_in_ready), 32'd1);
    check("mid_st",  101, 32'(bus.stall), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    bus.in_sel = 1'b1;
    #1;
    check("mid_empty_st", 102, 32'(bus.stall), 32'd1);
    check("mid_empty_rd", 102, 32'(bus.rd_data), 32'd0);
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
